// File: rtl/store_buffer.sv
// Store buffer between MEM stage and data memory: in-order FIFO drain with load-hazard detect.
// Optional STORE_MERGE_EN: a store to the newest entry's word merges into it instead of allocating.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       st_valid,
  input  logic [31:0]                st_addr,
  input  logic [31:0]                st_wdata,
  input  logic [3:0]                 st_mbe,
  output logic                       st_ready,
  input  logic                       ld_valid,
  input  logic [31:0]                ld_addr,
  output logic                       ld_hazard,
  output logic                       dmem_write,
  output logic [31:0]                dmem_address,
  output logic [31:0]                dmem_wdata,
  output logic [3:0]                 dmem_mbe,
  input  logic                       dmem_resp,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [29:0]     addr_q  [DEPTH];
  logic [29:0]     addr_d  [DEPTH];
  logic [31:0]     wdata_q [DEPTH];
  logic [31:0]     wdata_d [DEPTH];
  logic [3:0]      mbe_q   [DEPTH];
  logic [3:0]      mbe_d   [DEPTH];
  logic            dmem_write_q, dmem_write_d;
  logic [31:0]     dmem_address_q, dmem_address_d;
  logic [31:0]     dmem_wdata_q, dmem_wdata_d;
  logic [3:0]      dmem_mbe_q, dmem_mbe_d;

  logic            push_s, enq_s, merge_s, head_merge_s, pop_s;
  logic [PW-1:0]   newest_s;
  logic [31:0]     merged_wdata_s;
  logic [3:0]      merged_mbe_s;
  logic            hazard_s;
  logic            unused_s;

  assign unused_s = ^{st_addr[1:0], ld_addr[1:0]};

  // Push/merge decode and the merged view of the newest entry.
  always_comb begin
    push_s   = st_valid && st_ready && (st_mbe != 4'b0000);
    newest_s = tail_q - PTR_ONE;
`ifdef STORE_MERGE_EN
    merge_s  = push_s && (count_q != {CW{1'b0}}) &&
               (addr_q[newest_s] == st_addr[31:2]) &&
               !((state_q == WRITE) && (newest_s == head_q));
`else
    merge_s  = 1'b0;
`endif
    head_merge_s = merge_s && (newest_s == head_q);
    enq_s        = push_s && !merge_s;
    pop_s        = (state_q == WRITE) && dmem_resp;
    for (int b = 0; b < 4; b++) begin
      merged_wdata_s[8*b +: 8] = st_mbe[b] ? st_wdata[8*b +: 8] : wdata_q[newest_s][8*b +: 8];
    end
    merged_mbe_s = mbe_q[newest_s] | st_mbe;
  end

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mbe_d   = mbe_q;
    if (enq_s) begin
      addr_d[tail_q]  = st_addr[31:2];
      wdata_d[tail_q] = st_wdata;
      mbe_d[tail_q]   = st_mbe;
    end else if (merge_s) begin
      wdata_d[newest_s] = merged_wdata_s;
      mbe_d[newest_s]   = merged_mbe_s;
    end else begin
      addr_d = addr_q;
    end
    tail_d = enq_s ? tail_q + PTR_ONE : tail_q;
    head_d = pop_s ? head_q + PTR_ONE : head_q;
    case ({enq_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Drain FSM next state and registered dmem request fields.
  always_comb begin
    state_d        = state_q;
    dmem_write_d   = dmem_write_q;
    dmem_address_d = dmem_address_q;
    dmem_wdata_d   = dmem_wdata_q;
    dmem_mbe_d     = dmem_mbe_q;
    case (state_q)
      IDLE: begin
        if (count_q != {CW{1'b0}}) begin
          // A merge landing on the head this edge must be reflected in the launched write.
          state_d        = WRITE;
          dmem_write_d   = 1'b1;
          dmem_address_d = {addr_q[head_q], 2'b00};
          dmem_wdata_d   = head_merge_s ? merged_wdata_s : wdata_q[head_q];
          dmem_mbe_d     = head_merge_s ? merged_mbe_s : mbe_q[head_q];
        end else begin
          dmem_write_d = 1'b0;
        end
      end
      WRITE: begin
        if (dmem_resp) begin
          state_d      = IDLE;
          dmem_write_d = 1'b0;
        end else begin
          dmem_write_d = 1'b1;
        end
      end
      default: begin
        state_d      = IDLE;
        dmem_write_d = 1'b0;
      end
    endcase
  end

  // Word-match of the load against every live entry, including the in-flight head.
  always_comb begin
    hazard_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(PW'(i) - head_q) < count_q) && (addr_q[i] == ld_addr[31:2])) begin
        hazard_s = 1'b1;
      end else begin
        hazard_s = hazard_s;
      end
    end
  end

  // State, pointer, storage and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      head_q         <= {PW{1'b0}};
      tail_q         <= {PW{1'b0}};
      count_q        <= {CW{1'b0}};
      dmem_write_q   <= 1'b0;
      dmem_address_q <= 32'h0000_0000;
      dmem_wdata_q   <= 32'h0000_0000;
      dmem_mbe_q     <= 4'b0000;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i]  <= 30'h0000_0000;
        wdata_q[i] <= 32'h0000_0000;
        mbe_q[i]   <= 4'b0000;
      end
    end else begin
      state_q        <= state_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      dmem_write_q   <= dmem_write_d;
      dmem_address_q <= dmem_address_d;
      dmem_wdata_q   <= dmem_wdata_d;
      dmem_mbe_q     <= dmem_mbe_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      mbe_q          <= mbe_d;
    end
  end

  assign st_ready     = (count_q != CNT_FULL);
  assign empty        = (count_q == {CW{1'b0}});
  assign count        = count_q;
  assign ld_hazard    = ld_valid && hazard_s;
  assign dmem_write   = dmem_write_q;
  assign dmem_address = dmem_address_q;
  assign dmem_wdata   = dmem_wdata_q;
  assign dmem_mbe     = dmem_mbe_q;

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: stimulus queues expected dmem writes, a monitor checks them.
module tb_store_buffer;

  logic        clk, rst_n;
  logic        st_valid, ld_valid, dmem_resp;
  logic [31:0] st_addr, st_wdata, ld_addr;
  logic [3:0]  st_mbe;
  logic        st_ready, ld_hazard, dmem_write, empty;
  logic [31:0] dmem_address, dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic [2:0]  count;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   resp_en  = 1'b0;
  bit   resp_once = 1'b0;

  store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_addr(st_addr), .st_wdata(st_wdata), .st_mbe(st_mbe),
    .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
    .dmem_write(dmem_write), .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
    .dmem_mbe(dmem_mbe), .dmem_resp(dmem_resp),
    .empty(empty), .count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: answers an outstanding write while enabled, or once on request.
  initial begin
    dmem_resp = 1'b0;
    forever begin
      @(negedge clk);
      dmem_resp = dmem_write && (resp_en || resp_once);
      if (dmem_resp && resp_once) resp_once = 1'b0;
    end
  end

  // Monitor: each new write is compared against the queue head; held writes must stay stable.
  initial begin
    logic        prev;
    logic [31:0] ha, hd;
    logic [3:0]  hm;
    exp_t        e;
    prev = 1'b0; ha = 32'h0; hd = 32'h0; hm = 4'h0;
    forever begin
      @(negedge clk);
      if (dmem_write && !prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", dmem_address, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", dmem_address, e.a);
          chk("wr_data", dmem_wdata, e.d);
          chk("wr_mbe", {28'h0, dmem_mbe}, {28'h0, e.m});
        end
        ha = dmem_address; hd = dmem_wdata; hm = dmem_mbe;
      end else if (dmem_write && prev) begin
        chk("hold_addr", dmem_address, ha);
        chk("hold_data", dmem_wdata, hd);
        chk("hold_mbe", {28'h0, dmem_mbe}, {28'h0, hm});
      end
      prev = dmem_write;
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                      input bit wait_rdy, input bit enq);
    int   guard;
    bit   acc;
    exp_t e;
    @(negedge clk);
    guard = 0;
    while (wait_rdy && !st_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (wait_rdy && !st_ready) chk("push_ready_timeout", {31'h0, st_ready}, 32'h1);
    acc = st_ready;
    st_addr = a; st_wdata = d; st_mbe = m; st_valid = 1'b1;
    if (acc && enq && (m != 4'b0000)) begin
      e.a = {a[31:2], 2'b00}; e.d = d; e.m = m;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1 st_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!empty && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk(name, {31'h0, empty}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst_n = 1'b0; st_valid = 1'b0; st_addr = 32'h0; st_wdata = 32'h0; st_mbe = 4'h0;
    ld_valid = 1'b1; ld_addr = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_count", {29'h0, count}, 32'd0);
    chk("rst_empty", {31'h0, empty}, 32'h1);
    chk("rst_ready", {31'h0, st_ready}, 32'h1);
    chk("rst_write", {31'h0, dmem_write}, 32'h0);
    chk("rst_addr", dmem_address, 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_mbe", {28'h0, dmem_mbe}, 32'h0);
    chk("rst_hazard", {31'h0, ld_hazard}, 32'h0);
    ld_valid = 1'b0;
    rst_n = 1'b1;

    // single store: one-cycle launch latency, held through stalls
    push(32'h0000_1006, 32'h00AB_0000, 4'b0100, 1'b1, 1'b1);
    @(negedge clk);
    chk("lat_edge_n", {31'h0, dmem_write}, 32'h0);
    @(negedge clk);
    chk("lat_edge_n1", {31'h0, dmem_write}, 32'h1);
    chk("single_addr", dmem_address, 32'h0000_1004);
    repeat (3) @(negedge clk);
    resp_en = 1'b1;
    wait_empty("single_drain");
    chk("single_wr_low", {31'h0, dmem_write}, 32'h0);
    resp_en = 1'b0;

    // fill to capacity, reject a fifth, free one slot
    for (int i = 0; i < 4; i++) push(32'h10 + 32'(4*i), 32'hA000_0000 + 32'(i), 4'b1111, 1'b1, 1'b1);
    @(negedge clk);
    chk("full_count", {29'h0, count}, 32'd4);
    chk("full_ready", {31'h0, st_ready}, 32'h0);
    push(32'h0000_0080, 32'hDEAD_BEEF, 4'b1111, 1'b0, 1'b1);
    @(negedge clk);
    chk("full_reject", {29'h0, count}, 32'd4);
    resp_once = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("free_count", {29'h0, count}, 32'd3);
    chk("free_ready", {31'h0, st_ready}, 32'h1);
    resp_en = 1'b1;
    wait_empty("fill_drain");

    // ordering across pointer wrap with interleaved pushes
    for (int i = 0; i < 6; i++) begin
      push(32'h100 + 32'(4*i), 32'hC0DE_0000 + 32'(i), 4'b1111, 1'b1, 1'b1);
      if (i % 2 == 1) @(negedge clk);
    end
    wait_empty("order_drain");
    chk("order_left", 32'(exp_q.size()), 32'd0);

    // load hazard against a pending store
    resp_en = 1'b0;
    push(32'h200, 32'h1234_5678, 4'b1111, 1'b1, 1'b1);
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = 32'h202;
    #1 chk("haz_match", {31'h0, ld_hazard}, 32'h1);
    ld_addr = 32'h204;
    #1 chk("haz_other_word", {31'h0, ld_hazard}, 32'h0);
    ld_valid = 1'b0; ld_addr = 32'h202;
    #1 chk("haz_no_valid", {31'h0, ld_hazard}, 32'h0);
    resp_en = 1'b1;
    wait_empty("haz_drain");
    ld_valid = 1'b1;
    #1 chk("haz_after_drain", {31'h0, ld_hazard}, 32'h0);
    ld_valid = 1'b0;

    // zero-mask store, then reset in the middle of a write
    resp_en = 1'b0;
    push(32'h300, 32'hFFFF_FFFF, 4'b0000, 1'b1, 1'b1);
    @(negedge clk);
    chk("zero_mbe_count", {29'h0, count}, 32'd0);
    @(negedge clk);
    chk("zero_mbe_nowrite", {31'h0, dmem_write}, 32'h0);
    push(32'h400, 32'h4444_4444, 4'b1111, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_write", {31'h0, dmem_write}, 32'h1);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_write", {31'h0, dmem_write}, 32'h0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_count", {29'h0, count}, 32'd0);
    chk("post_rst_empty", {31'h0, empty}, 32'h1);

    // two stores to one word while a different head is in flight
    push(32'h500, 32'h5555_5555, 4'b1111, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
`ifdef STORE_MERGE_EN
    push(32'h300, 32'h0000_0011, 4'b0001, 1'b1, 1'b0);
    push(32'h301, 32'h0000_2200, 4'b0010, 1'b1, 1'b0);
    e.a = 32'h300; e.d = 32'h0000_2211; e.m = 4'b0011;
    exp_q.push_back(e);
    @(negedge clk);
    chk("merge_count", {29'h0, count}, 32'd2);
`else
    push(32'h300, 32'h0000_0011, 4'b0001, 1'b1, 1'b1);
    push(32'h301, 32'h0000_2200, 4'b0010, 1'b1, 1'b1);
    @(negedge clk);
    chk("nomerge_count", {29'h0, count}, 32'd3);
`endif
    resp_en = 1'b1;
    wait_empty("merge_drain");
    chk("merge_left", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Buffers data-memory stores between the MEM stage and the data-memory port.
- Input comes from the MEM-stage store path: the store-data byte-lane shifter output plus its 4-bit byte mask.
- Holds up to DEPTH stores and drains them in order to dmem with a write/resp handshake, so store misses do not stall the pipeline.
- Flags loads that hit a pending store's word, so the pipeline stalls the load until that store drains.

Parameters:
- DEPTH, 4, number of buffered stores; power of 2, at least 2.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- st_valid  input  1  store request from MEM stage
- st_addr  input  32  store byte address; only bits [31:2] are used
- st_wdata  input  32  lane-aligned store data from the shifter
- st_mbe  input  4  byte-enable mask
- st_ready  output  1  buffer can accept a store this cycle
- ld_valid  input  1  a load is in MEM this cycle
- ld_addr  input  32  load byte address
- ld_hazard  output  1  load word matches a pending store
- dmem_write  output  1  write request to data memory
- dmem_address  output  32  word-aligned write address
- dmem_wdata  output  32  write data
- dmem_mbe  output  4  write byte mask
- dmem_resp  input  1  memory has completed the write
- empty  output  1  no pending stores
- count  output  $clog2(DEPTH+1)  number of valid entries

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values:
  - pointers 0, count 0, empty 1, st_ready 1
  - dmem_write 0, dmem_address 0, dmem_wdata 0, dmem_mbe 0
  - ld_hazard 0; FSM in IDLE.
- Storage: circular FIFO with head and tail pointers that wrap modulo DEPTH.
  - Each entry holds {addr[31:2], wdata, mbe}.
- Push:
  - st_ready = (count != DEPTH). It does not depend on a same-cycle pop.
  - A store is accepted when st_valid & st_ready.
  - If st_mbe == 4'b0000, the handshake completes but nothing is enqueued.
  - Otherwise the entry is written at tail and tail advances.
- Drain FSM, states IDLE and WRITE:
  - IDLE -> WRITE on the next edge when count != 0 (count as registered).
  - In WRITE, dmem_write=1 and dmem_address={head.addr,2'b00}. dmem_wdata and dmem_mbe come from head. All are held stable until dmem_resp.
  - WRITE with dmem_resp: pop head and go to IDLE. dmem_write is low for at least 1 cycle between writes.
  - dmem_resp while in IDLE is ignored.
- Latency: a store pushed into an empty buffer at edge N gives dmem_write=1 after edge N+1.
- Simultaneous push and pop: count is unchanged and both pointers advance. Push while full is impossible because st_ready is 0.
- ld_hazard is combinational: ld_valid & (any valid entry has addr == ld_addr[31:2]).
  - Entries include the head that is in flight.
  - Byte overlap is not checked; a word match is a hazard.
  - A store pushed in the same cycle as the load is not compared.
- empty = (count == 0).
- Reset mid-write: dmem_write drops immediately (asynchronous) and all entries are discarded.

Optional Feature:
- Macro: STORE_MERGE_EN
- Defined: on push, the store merges into the newest entry when all of these hold:
  - count != 0
  - the newest entry's addr == st_addr[31:2]
  - the newest entry is not the head while in WRITE
- Merge rules:
  - Each byte with st_mbe[i]=1 overwrites that byte.
  - The entry's mask becomes old_mbe | st_mbe.
  - count and tail are unchanged.
- st_ready is unchanged (still !full).
- Not defined: every non-zero-mask store takes a new entry.

Test Plan:
- Single store: push addr 0x0000_1006, wdata 0x00AB_0000, mbe 4'b0100 into an empty buffer.
  - Required: one cycle later dmem_write=1, dmem_address 0x0000_1004, wdata 0x00AB_0000, mbe 4'b0100.
  - These hold through 3 stall cycles. After dmem_resp: empty=1, dmem_write=0.
- Fill: push 4 stores with dmem_resp tied 0.
  - Required: count=4, st_ready=0, and a 5th st_valid is not accepted.
  - One dmem_resp frees a slot: count=3, st_ready=1.
- Ordering and wrap: push 6 stores to 0x100, 0x104, ... with resp always 1 and pushes interleaved.
  - Required: dmem writes in push order, with correct data after pointer wrap.
- Load hazard:
  - Pending store at 0x200: ld_addr 0x202 gives ld_hazard=1; ld_addr 0x204 gives 0; ld_valid=0 gives 0.
  - After drain, ld_addr 0x202 gives 0.
- Zero mask and reset: a push with mbe 0 leaves count unchanged.
  - Assert rst_n=0 mid-WRITE: dmem_write=0 the same cycle, count=0 after release.
- STORE_MERGE_EN:
  - Push 0x300/0x0000_0011/0001, then 0x301/0x0000_2200/0010, while the head (a different address) is in WRITE.
  - Required: count increases by 1 only, and the entry drains as 0x300, 0x0000_2211, mbe 0011.
  - Without the macro, the same stimulus produces two separate writes.
